bcd_xs3_codec: RTL
==================

// Module: bcd_xs3_codec
// PURPOSE
//   Multi-digit, digit-serial codec between packed BCD and Excess-3 (XS3).
//   Mode 0 encodes BCD to XS3; mode 1 decodes XS3 to BCD.
//   Converts one digit per clock, least-significant digit first.
//   Flags illegal digits per position.
//   Sits between a decimal datapath and display/arith blocks.
//   Uses valid/ready handshakes on both input and output.
// PARAMETERS
//   NDIG  4  number of 4-bit digits per word (>=1)
// PORTS
//   clk           in   1        rising-edge clock
//   rst           in   1        asynchronous, active-high reset
//   in_valid      in   1        input word offered
//   in_ready      out  1        codec can accept a word
//   in_mode       in   1        0 = BCD->XS3, 1 = XS3->BCD
//   in_data       in   4*NDIG   packed digits; digit i = [4i+3:4i]
//   out_valid     out  1        converted word available
//   out_ready     in   1        consumer accepts the word
//   out_data      out  4*NDIG   converted digits
//   out_err_mask  out  NDIG     bit i = 1: digit i was illegal
//   out_err       out  1        OR-reduction of out_err_mask
//   out_mode      out  1        mode captured with the word
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - state=IDLE, digit index=0.
//   - out_valid, out_data, out_err_mask, out_err and out_mode all 0.
//   - in_ready=0 while rst is high.
//   States:
//   - IDLE: in_ready = ~rst.
//     - in_valid & in_ready at an edge: capture in_data and in_mode,
//       clear out_data and the mask, idx=0, go to CONV.
//   - CONV: in_ready=0; each cycle convert digit idx.
//     - Write the result into out_data slot idx and the flag into mask bit idx.
//     - idx++. When idx==NDIG-1, go to HOLD.
//   - HOLD: out_valid=1.
//     - out_data, mask, out_err and out_mode are stable until out_ready.
//     - On out_valid & out_ready: out_valid=0, go to IDLE.
//   Timing:
//   - out_valid rises NDIG+1 edges after the accepting edge.
//   - Minimum spacing between accepted words is NDIG+2 cycles.
//   - No input/output overlap.
//   Digit arithmetic is 4-bit with no carry between digits:
//   - Mode 0: legal d in 0..9, result d+3. Illegal d in 10..15.
//   - Mode 1: legal d in 3..12, result d-3. Illegal d in 0..2 or 13..15.
//   - Illegal digit: result 4'hF, mask bit set. Other digits still convert.
//   Boundaries:
//   - in_data and in_mode changing during CONV or HOLD: ignored.
//   - in_valid asserted while not in IDLE: not accepted, no side effects.
//   - out_ready high outside HOLD: ignored.
//   - rst asserted mid-CONV or in HOLD: word discarded, outputs cleared
//     immediately, no out_valid pulse.
//   - NDIG=1: CONV lasts exactly 1 cycle. idx width = max(1, $clog2(NDIG)).
// STRUCTURE
//   Shared package bcd_pkg:
//   - XS3_OFFSET=4'd3, BCD_MAX=4'd9, XS3_MIN=4'd3, XS3_MAX=4'd12.
//   - ERR_DIGIT=4'hF.
//   - State encoding: IDLE=2'd0, CONV=2'd1, HOLD=2'd2.
//   Sub-module xs3_digit (combinational):
//   - Inputs d[3:0], mode. Outputs q[3:0], bad.
//   - A single instance is time-shared by the CONV loop.
//   Top level: FSM, idx counter, capture register, output shift/slot registers.
// TESTING
//   T1 rst pulse mid-idle and mid-CONV -> all outputs 0, in_ready 0
//      while rst high, in_ready 1 the cycle after release.
//   T2 NDIG=4, mode0, in_data=16'h1937 -> after 5 edges out_data=16'h4C6A,
//      mask=4'b0000, out_err=0, out_mode=0.
//   T3 mode1, in_data=16'h4C6A -> out_data=16'h1937, out_err=0, out_mode=1.
//   T4 illegal digits:
//      mode0 16'h12A9 -> 16'h45FC, mask=4'b0010, out_err=1.
//      mode1 16'h0D33 -> 16'hFF00, mask=4'b1100.
//   T5 backpressure: out_ready low 6 cycles -> out_valid and data stable,
//      in_ready 0, competing in_valid not accepted.
//      Then out_ready=1 -> 1-cycle handshake, IDLE next.
//   T6 NDIG=1 sweep, both modes, all 16 input codes -> results/flags match
//      the digit rules; out_valid 2 edges after acceptance.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD/XS3 codec.
// Imported by xs3_digit and bcd_xs3_codec.
package bcd_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;
  localparam logic [3:0] ERR_DIGIT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/xs3_digit.sv
// Single-digit BCD<->XS3 converter (combinational).
// Ports: d/mode in (mode 0 = +3, mode 1 = -3); q result, bad = illegal code.
import bcd_pkg::*;

module xs3_digit (
  input  logic [3:0] d,
  input  logic       mode,
  output logic [3:0] q,
  output logic       bad
);

  always_comb begin
    bad = 1'b0;
    q   = ERR_DIGIT;
    if (mode) begin
      bad = (d < XS3_MIN) || (d > XS3_MAX);
      if (!bad) q = d - XS3_OFFSET;
    end else begin
      bad = (d > BCD_MAX);
      if (!bad) q = d + XS3_OFFSET;
    end
  end

endmodule

// File: rtl/bcd_xs3_codec.sv
// Digit-serial packed BCD <-> Excess-3 codec, LSD first, one digit per clock.
// Ports: clk, rst (async high); in_* valid/ready word input with mode;
//        out_* valid/ready word output with data, per-digit error mask,
//        OR'd error flag and captured mode.
import bcd_pkg::*;

module bcd_xs3_codec #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [4*NDIG-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic [NDIG-1:0]   out_err_mask,
  output logic              out_err,
  output logic              out_mode
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NDIG-1:0][3:0]   cap_q, cap_d;
  logic                   mode_q, mode_d;
  logic [NDIG-1:0][3:0]   odat_q, odat_d;
  logic [NDIG-1:0]        mask_q, mask_d;
  logic                   vld_q, vld_d;

  logic [3:0] dig;
  logic [3:0] res;
  logic       bad;

  // Select the digit currently being converted.
  always_comb begin
    dig = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) dig = cap_q[i];
    end
  end

  xs3_digit u_dig (
    .d    (dig),
    .mode (mode_q),
    .q    (res),
    .bad  (bad)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    mode_d  = mode_q;
    odat_d  = odat_q;
    mask_d  = mask_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          cap_d   = in_data;
          mode_d  = in_mode;
          odat_d  = '0;
          mask_d  = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < NDIG; i++) begin
          if (idx_q == IW'(i)) begin
            odat_d[i] = res;
            mask_d[i] = bad;
          end
        end
        if (idx_q == LAST) begin
          idx_d   = '0;
          vld_d   = 1'b1;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
      mode_q  <= 1'b0;
      odat_q  <= '0;
      mask_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      mode_q  <= mode_d;
      odat_q  <= odat_d;
      mask_q  <= mask_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready     = (state_q == IDLE) && !rst;
  assign out_valid    = vld_q;
  assign out_data     = odat_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;
  assign out_mode     = mode_q;

endmodule
